dmem_arbiter: RTL and testbench

- Shares the single data-memory port between the CPU datapath (port C) and a DMA/program-loader engine (port D).
- Round-robin arbitration with a four-state access sequencer.
- Handles variable read latency and returns read data or a write acknowledgement to whichever requester was granted.
- Sits between the requester load/store interfaces and the data-memory block.

---
 rtl/dmem_arbiter_if.sv | 55 +++++
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports (C = CPU, D = DMA/loader) and the data-memory port.
// d_lock exists only when DMEM_ARB_LOCK_EN is defined.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              c_req;
   logic              c_we;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wdata;
   logic              c_gnt;
   logic              c_rvalid;
   logic [DATA_W-1:0] c_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
`ifdef DMEM_ARB_LOCK_EN
   logic              d_lock;
`endif

   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic              m_rd;
   logic              m_wr;
   logic [DATA_W-1:0] m_rdata;

   modport master (
`ifdef DMEM_ARB_LOCK_EN
      input  d_lock,
`endif
      input  c_req, c_we, c_addr, c_wdata,
      output c_gnt, c_rvalid, c_rdata,
      input  d_req, d_we, d_addr, d_wdata,
      output d_gnt, d_rvalid, d_rdata,
      output m_addr, m_wdata, m_rd, m_wr,
      input  m_rdata
   );

   modport slave (
`ifdef DMEM_ARB_LOCK_EN
      output d_lock,
`endif
      output c_req, c_we, c_addr, c_wdata,
      input  c_gnt, c_rvalid, c_rdata,
      output d_req, d_we, d_addr, d_wdata,
      input  d_gnt, d_rvalid, d_rdata,
      input  m_addr, m_wdata, m_rd, m_wr,
      output m_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU (C) and DMA/loader (D).
// Optional macro DMEM_ARB_LOCK_EN adds d_lock so the loader can hold the port for atomic bursts.
module dmem_arbiter #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int MEM_LAT = 1
) (
   input  logic           CLK,
   input  logic           resetl,
   dmem_arbiter_if.master bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

   state_t            state_r, state_s;
   logic              owner_r;    // 1 = D owns the current access
   logic              we_r;
   logic              last_d_r;   // 1 = D was served last
   logic [2:0]        cnt_r;
   logic [ADDR_W-1:0] m_addr_r;
   logic [DATA_W-1:0] m_wdata_r;
   logic              m_rd_r, m_wr_r;
   logic              c_rvalid_r, d_rvalid_r;
   logic [DATA_W-1:0] c_rdata_r, d_rdata_r;

   logic              grant_c_s, grant_d_s, d_prio_s, sel_we_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_wdata_s;

`ifdef DMEM_ARB_LOCK_EN
   logic              lock_r;
   assign d_prio_s = lock_r & bus.d_lock;
`else
   assign d_prio_s = 1'b0;
`endif

   // Next-state and grant decode; grants only leave IDLE and never during reset
   always_comb begin
      state_s   = state_r;
      grant_c_s = 1'b0;
      grant_d_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (resetl) begin
               state_s = ST_IDLE;
            end else if (d_prio_s) begin
               grant_d_s = bus.d_req;
               state_s   = bus.d_req ? ST_ISSUE : ST_IDLE;
            end else if (bus.c_req && (!bus.d_req || last_d_r)) begin
               grant_c_s = 1'b1;
               state_s   = ST_ISSUE;
            end else if (bus.d_req) begin
               grant_d_s = 1'b1;
               state_s   = ST_ISSUE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: state_s = we_r ? ST_DONE : ST_WAIT;
         ST_WAIT:  state_s = (cnt_r == 3'd0) ? ST_DONE : ST_WAIT;
         ST_DONE:  state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // Request fields of the winning port
   always_comb begin
      if (grant_d_s) begin
         sel_we_s    = bus.d_we;
         sel_addr_s  = bus.d_addr;
         sel_wdata_s = bus.d_wdata;
      end else begin
         sel_we_s    = bus.c_we;
         sel_addr_s  = bus.c_addr;
         sel_wdata_s = bus.c_wdata;
      end
   end

   // Sequencer state, latched request, memory strobes and completion registers
   always_ff @(posedge CLK) begin
      if (resetl) begin
         state_r    <= ST_IDLE;
         owner_r    <= 1'b0;
         we_r       <= 1'b0;
         last_d_r   <= 1'b1;
         cnt_r      <= 3'd0;
         m_addr_r   <= '0;
         m_wdata_r  <= '0;
         m_rd_r     <= 1'b0;
         m_wr_r     <= 1'b0;
         c_rvalid_r <= 1'b0;
         d_rvalid_r <= 1'b0;
         c_rdata_r  <= '0;
         d_rdata_r  <= '0;
`ifdef DMEM_ARB_LOCK_EN
         lock_r     <= 1'b0;
`endif
      end else begin
         state_r <= state_s;
         if (grant_c_s || grant_d_s) begin
            owner_r <= grant_d_s;
            we_r    <= sel_we_s;
         end
         // m_addr/m_wdata double as the latched request and are only non-zero in ISSUE
         m_rd_r     <= (grant_c_s || grant_d_s) && !sel_we_s;
         m_wr_r     <= (grant_c_s || grant_d_s) && sel_we_s;
         m_addr_r   <= (grant_c_s || grant_d_s) ? sel_addr_s : '0;
         m_wdata_r  <= (grant_c_s || grant_d_s) ? sel_wdata_s : '0;
         c_rvalid_r <= (state_s == ST_DONE) && !owner_r;
         d_rvalid_r <= (state_s == ST_DONE) && owner_r;
         if (state_r == ST_ISSUE) begin
            cnt_r <= CNT_INIT;
         end else if (state_r == ST_WAIT && cnt_r != 3'd0) begin
            cnt_r <= cnt_r - 3'd1;
         end
         if (state_r == ST_WAIT && cnt_r == 3'd0) begin
            if (owner_r) d_rdata_r <= bus.m_rdata;
            else         c_rdata_r <= bus.m_rdata;
         end
         if (state_r == ST_DONE) begin
`ifdef DMEM_ARB_LOCK_EN
            // A locked D completion keeps the pointer so D stays in front
            if (owner_r && bus.d_lock) lock_r <= 1'b1;
            else                       last_d_r <= owner_r;
`else
            last_d_r <= owner_r;
`endif
         end
`ifdef DMEM_ARB_LOCK_EN
         if (state_r == ST_IDLE && !bus.d_lock) lock_r <= 1'b0;
`endif
      end
   end

   assign bus.c_gnt    = grant_c_s;
   assign bus.d_gnt    = grant_d_s;
   assign bus.c_rvalid = c_rvalid_r;
   assign bus.d_rvalid = d_rvalid_r;
   assign bus.c_rdata  = c_rdata_r;
   assign bus.d_rdata  = d_rdata_r;
   assign bus.m_addr   = m_addr_r;
   assign bus.m_wdata  = m_wdata_r;
   assign bus.m_rd     = m_rd_r;
   assign bus.m_wr     = m_wr_r;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a transaction-timeline reference model.
// Lock scenarios are exercised when DMEM_ARB_LOCK_EN is defined.
module tb_dmem_arbiter;
   localparam int ADDR_W  = 64;
   localparam int DATA_W  = 64;
   localparam int MEM_LAT = 3;

   logic clk = 1'b0;
   logic resetl;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
      .CLK(clk), .resetl(resetl), .bus(bus));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
   endtask

   // Initial memory contents: word 8 (address 0x40) holds 0x1234
   function automatic logic [63:0] mem_init(input logic [7:0] idx);
      return (idx == 8'd8) ? 64'h1234 : {8'hA5, 48'(idx) * 48'h9E37_79B9, idx};
   endfunction

   // Environment memory with a MEM_LAT-deep read pipe; junk otherwise
   logic [63:0] env_mem [256];
   bit          env_wr  [256];
   logic [63:0] pipe_d  [1:MEM_LAT];
   bit          pipe_v  [1:MEM_LAT];
   logic [63:0] junk;
   always @(posedge clk) begin
      if (bus.m_wr) begin
         env_mem[bus.m_addr[10:3]] <= bus.m_wdata;
         env_wr[bus.m_addr[10:3]]  <= 1'b1;
      end
      pipe_v[1] <= bus.m_rd;
      pipe_d[1] <= env_wr[bus.m_addr[10:3]] ? env_mem[bus.m_addr[10:3]] : mem_init(bus.m_addr[10:3]);
      for (int k = 2; k <= MEM_LAT; k++) begin
         pipe_v[k] <= pipe_v[k-1];
         pipe_d[k] <= pipe_d[k-1];
      end
      junk <= {$urandom, $urandom};
   end
   assign bus.m_rdata = pipe_v[MEM_LAT] ? pipe_d[MEM_LAT] : junk;

   // Requester drivers
   bit pc, pd, c_we_v, d_we_v, lock_v;
   logic [63:0] c_addr_v, c_wdata_v, d_addr_v, d_wdata_v;
   int p_new = 0, p_drop = 0;

   // Reference model: one outstanding access described by its grant cycle
   logic [63:0] ref_mem [256];
   bit          ref_wr  [256];
   int cyc = 0, a_g = 0, n_dg = 0;
   bit act = 1'b0, a_d = 1'b0, a_we = 1'b0, last_d = 1'b1, lk = 1'b0;
   logic [63:0] a_addr = '0, a_wdata = '0, a_rd = '0, crd = '0, drd = '0;

   task automatic req(input bit is_d, input bit we, input logic [63:0] addr, input logic [63:0] data);
      if (is_d) begin pd = 1'b1; d_we_v = we; d_addr_v = addr; d_wdata_v = data; end
      else      begin pc = 1'b1; c_we_v = we; c_addr_v = addr; c_wdata_v = data; end
   endtask

   task automatic new_req(input bit is_d);
      req(is_d, 1'($urandom), {53'd0, 8'($urandom), 3'd0}, {$urandom, $urandom});
   endtask

   task automatic drive();
      bus.c_req   = pc;
      bus.c_we    = pc ? c_we_v : 1'($urandom);
      bus.c_addr  = pc ? c_addr_v : {$urandom, $urandom};
      bus.c_wdata = pc ? c_wdata_v : {$urandom, $urandom};
      bus.d_req   = pd;
      bus.d_we    = pd ? d_we_v : 1'($urandom);
      bus.d_addr  = pd ? d_addr_v : {$urandom, $urandom};
      bus.d_wdata = pd ? d_wdata_v : {$urandom, $urandom};
`ifdef DMEM_ARB_LOCK_EN
      bus.d_lock  = lock_v;
`endif
   endtask

   task automatic tick();
      bit gc, gd, issue, done, capt;
      int dur;
      dur = a_we ? 3 : MEM_LAT + 3;
      if (act && cyc >= a_g + dur) act = 1'b0;
      gc = 1'b0;
      gd = 1'b0;
      if (!resetl && !act) begin
         if (lk && lock_v)    gd = pd;
         else if (pc && pd) begin gc = last_d; gd = !last_d; end
         else begin gc = pc; gd = pd; end
      end
      issue = act && (cyc == a_g + 1);
      done  = act && (cyc == a_g + dur - 1);
      capt  = act && !a_we && (cyc == a_g + 1 + MEM_LAT);
      @(negedge clk);
      check("c_gnt",    bus.c_gnt, gc);
      check("d_gnt",    bus.d_gnt, gd);
      check("m_rd",     bus.m_rd, issue && !a_we);
      check("m_wr",     bus.m_wr, issue && a_we);
      check("m_addr",   bus.m_addr, issue ? a_addr : 64'd0);
      check("m_wdata",  bus.m_wdata, issue ? a_wdata : 64'd0);
      check("c_rvalid", bus.c_rvalid, done && !a_d);
      check("d_rvalid", bus.d_rvalid, done && a_d);
      check("c_rdata",  bus.c_rdata, crd);
      check("d_rdata",  bus.d_rdata, drd);
      if (issue && a_we) begin
         ref_mem[a_addr[10:3]] = a_wdata;
         ref_wr[a_addr[10:3]]  = 1'b1;
      end
      if (issue && !a_we) a_rd = ref_wr[a_addr[10:3]] ? ref_mem[a_addr[10:3]] : mem_init(a_addr[10:3]);
      if (capt) begin
         if (a_d) drd = a_rd;
         else     crd = a_rd;
      end
`ifdef DMEM_ARB_LOCK_EN
      if (done) begin
         if (a_d && lock_v) lk = 1'b1;
         else               last_d = a_d;
      end
      if (!act && !lock_v) lk = 1'b0;
`else
      if (done) last_d = a_d;
`endif
      if (gc || gd) begin
         act     = 1'b1;
         a_d     = gd;
         a_we    = gd ? d_we_v : c_we_v;
         a_addr  = gd ? d_addr_v : c_addr_v;
         a_wdata = gd ? d_wdata_v : c_wdata_v;
         a_g     = cyc;
         if (gd) begin pd = 1'b0; n_dg++; end
         else    pc = 1'b0;
      end
      if (resetl) begin
         act = 1'b0; crd = '0; drd = '0; last_d = 1'b1; lk = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic step(input bit rst);
      if (pc && p_drop > 0 && $urandom_range(99) < p_drop) pc = 1'b0;
      else if (!pc && $urandom_range(99) < p_new) new_req(1'b0);
      if (pd && p_drop > 0 && $urandom_range(99) < p_drop) pd = 1'b0;
      else if (!pd && $urandom_range(99) < p_new) new_req(1'b1);
      resetl = rst;
      drive();
      tick();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0);
   endtask

   initial begin
      int budget;
      lock_v = 1'b0;
      // Two reset cycles with both ports requesting; C must win once released
      new_req(1'b0);
      new_req(1'b1);
      resetl = 1'b1;
      drive();
      @(posedge clk);
      #1;
      step(1'b1);
      run(14);

      // Directed: C read of 0x40, D write 0xDEAD to 0x80, C read back 0x80
      req(1'b0, 1'b0, 64'h40, 64'd0);
      run(10);
      req(1'b1, 1'b1, 64'h80, 64'hDEAD);
      run(6);
      req(1'b0, 1'b0, 64'h80, 64'd0);
      run(10);

      // Continuous contention
      p_new = 100;
      run(40);
      p_new = 0;
      run(20);

      // Reset while a read is in WAIT
      req(1'b0, 1'b0, 64'h100, 64'd0);
      budget = 20;
      while (!(act && !a_we && cyc == a_g + 2) && budget > 0) begin
         step(1'b0);
         budget--;
      end
      check("rst_mid_wait_reached", 64'(budget > 0), 64'd1);
      step(1'b1);
      req(1'b0, 1'b0, 64'h108, 64'd0);
      req(1'b1, 1'b0, 64'h110, 64'd0);
      run(20);

`ifdef DMEM_ARB_LOCK_EN
      // Locked loader burst: three D grants, then release with C waiting
      step(1'b1);
      lock_v = 1'b1;
      p_new  = 100;
      n_dg   = 0;
      budget = 80;
      while (n_dg < 3 && budget > 0) begin
         step(1'b0);
         budget--;
      end
      check("lock_three_d_grants", 64'(n_dg), 64'd3);
      lock_v = 1'b0;
      run(30);
      p_new = 0;
      run(20);
`endif

      // Random traffic with drops and occasional resets
      p_new  = 30;
      p_drop = 5;
      for (int i = 0; i < 3000; i++) begin
`ifdef DMEM_ARB_LOCK_EN
         if ($urandom_range(7) == 0) lock_v = ~lock_v;
`endif
         step($urandom_range(299) == 0);
      end
      p_new  = 0;
      p_drop = 0;
      lock_v = 1'b0;
      run(30);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
